// File: rtl/opl3_phase_acc.sv
// Per-operator phase accumulator (NCO) for the OPL3 operator pipeline.
// Three register levels: input capture, accumulator read, then update plus output.
module opl3_phase_acc #(
    parameter int PHASE_ACC_WIDTH = 20,
    parameter int NUM_BANKS       = 2,
    parameter int OPS_PER_BANK    = 18,
    parameter int PHASE_OUT_WIDTH = 10
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      slot_en,
    input  logic [$clog2(NUM_BANKS)-1:0]              bank_num,
    input  logic [$clog2(OPS_PER_BANK)-1:0]           op_num,
    input  logic [PHASE_ACC_WIDTH-1:0]                phase_inc,
    input  logic                                      key_on,
    input  logic [PHASE_OUT_WIDTH-1:0]                modulation,
    output logic                                      phase_valid,
    output logic [PHASE_OUT_WIDTH-1:0]                phase_out,
    output logic [$clog2(NUM_BANKS*OPS_PER_BANK)-1:0] phase_slot
);

    localparam int NUM_SLOTS = NUM_BANKS * OPS_PER_BANK;
    localparam int SLOT_W    = $clog2(NUM_SLOTS);
    localparam int BANK_W    = $clog2(NUM_BANKS);
    localparam int OP_W      = $clog2(OPS_PER_BANK);
    localparam int IDX_W     = BANK_W + OP_W + 1;
    localparam int ACC_W     = PHASE_ACC_WIDTH;
    localparam int OUT_W     = PHASE_OUT_WIDTH;

    localparam logic [OP_W:0]      OPS_LIM   = (OP_W + 1)'(OPS_PER_BANK);
    localparam logic [IDX_W-1:0]   SLOTS_LIM = IDX_W'(NUM_SLOTS);
    localparam logic [IDX_W-1:0]   OPS_MUL   = IDX_W'(OPS_PER_BANK);

    // Handshake: no backpressure. slot_en qualifies the slot inputs for one
    // cycle; phase_valid is a one-cycle pulse qualifying phase_out/phase_slot,
    // which hold their last values while phase_valid is low.

    logic [IDX_W-1:0] raw_idx;
    logic             slot_ok;

    assign raw_idx = IDX_W'(bank_num) * OPS_MUL + IDX_W'(op_num);
    assign slot_ok = ({1'b0, op_num} < OPS_LIM) && (raw_idx < SLOTS_LIM);

    logic              p1_valid_q;
    logic [SLOT_W-1:0] p1_slot_q;
    logic [ACC_W-1:0]  p1_inc_q;
    logic              p1_kon_q;
    logic [OUT_W-1:0]  p1_mod_q;

    logic              p2_valid_q;
    logic [SLOT_W-1:0] p2_slot_q;
    logic [ACC_W-1:0]  p2_inc_q;
    logic              p2_kon_q;
    logic [OUT_W-1:0]  p2_mod_q;
    logic [ACC_W-1:0]  p2_acc_q;
    logic              p2_kprev_q;

    logic [ACC_W-1:0]  acc_q [NUM_SLOTS];
    logic              kon_prev_q [NUM_SLOTS];

    logic              phase_valid_q;
    logic [OUT_W-1:0]  phase_out_q;
    logic [SLOT_W-1:0] phase_slot_q;

    logic              fwd_hit;
    logic [ACC_W-1:0]  rd_acc;
    logic              rd_kprev;
    logic [ACC_W-1:0]  acc_d;
    logic [OUT_W-1:0]  phase_out_d;

    always_comb begin
        acc_d = '0;
        if (!(p2_kon_q && !p2_kprev_q)) begin
            acc_d = p2_acc_q + p2_inc_q;
        end
        phase_out_d = acc_d[ACC_W-1 -: OUT_W] + p2_mod_q;
    end

    // A slot presented on consecutive cycles reads the value being written now.
    always_comb begin
        fwd_hit  = p2_valid_q && (p2_slot_q == p1_slot_q);
        rd_acc   = acc_q[p1_slot_q];
        rd_kprev = kon_prev_q[p1_slot_q];
        if (fwd_hit) begin
            rd_acc   = acc_d;
            rd_kprev = p2_kon_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_valid_q <= 1'b0;
            p1_slot_q  <= '0;
            p1_inc_q   <= '0;
            p1_kon_q   <= 1'b0;
            p1_mod_q   <= '0;
            p2_valid_q <= 1'b0;
            p2_slot_q  <= '0;
            p2_inc_q   <= '0;
            p2_kon_q   <= 1'b0;
            p2_mod_q   <= '0;
            p2_acc_q   <= '0;
            p2_kprev_q <= 1'b0;
        end else begin
            p1_valid_q <= slot_en && slot_ok;
            p1_slot_q  <= raw_idx[SLOT_W-1:0];
            p1_inc_q   <= phase_inc;
            p1_kon_q   <= key_on;
            p1_mod_q   <= modulation;
            p2_valid_q <= p1_valid_q;
            p2_slot_q  <= p1_slot_q;
            p2_inc_q   <= p1_inc_q;
            p2_kon_q   <= p1_kon_q;
            p2_mod_q   <= p1_mod_q;
            p2_acc_q   <= rd_acc;
            p2_kprev_q <= rd_kprev;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                acc_q[i]      <= '0;
                kon_prev_q[i] <= 1'b0;
            end
        end else if (p2_valid_q) begin
            acc_q[p2_slot_q]      <= acc_d;
            kon_prev_q[p2_slot_q] <= p2_kon_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_valid_q <= 1'b0;
            phase_out_q   <= '0;
            phase_slot_q  <= '0;
        end else begin
            phase_valid_q <= p2_valid_q;
            if (p2_valid_q) begin
                phase_out_q  <= phase_out_d;
                phase_slot_q <= p2_slot_q;
            end
        end
    end

    assign phase_valid = phase_valid_q;
    assign phase_out   = phase_out_q;
    assign phase_slot  = phase_slot_q;

endmodule

// File: doc/opl3_phase_acc.md
# opl3_phase_acc

Per-operator phase accumulator (NCO) for the OPL3 operator pipeline. It consumes the per-slot phase increment produced by the phase-increment stage, keeps one accumulator per operator slot across both banks, and emits the registered 10-bit operator phase, with FM modulation applied, to the waveform/sine-table stage. Accumulators advance once per sample period, when the sequencer presents each slot. A rising edge of key-on resets that slot's phase.

## Interface
Parameters:
- PHASE_ACC_WIDTH, 20, accumulator and phase-increment width.
- NUM_BANKS, 2, register banks.
- OPS_PER_BANK, 18, operator slots per bank; slot index = bank_num*OPS_PER_BANK + op_num.
- PHASE_OUT_WIDTH, 10, output phase width (top bits of the accumulator).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- slot_en  in  1  a slot is presented this cycle; phase_inc, bank_num, op_num, key_on and modulation are valid.
- bank_num  in  $clog2(NUM_BANKS)  bank of the presented slot.
- op_num  in  $clog2(OPS_PER_BANK)  operator within the bank.
- phase_inc  in  PHASE_ACC_WIDTH  unsigned increment for the slot.
- key_on  in  1  current key-on state of the slot's channel.
- modulation  in  PHASE_OUT_WIDTH  phase offset from the modulator operator, added modulo 2^PHASE_OUT_WIDTH.
- phase_valid  out  1  phase_out is valid.
- phase_out  out  PHASE_OUT_WIDTH  modulated operator phase.
- phase_slot  out  $clog2(NUM_BANKS*OPS_PER_BANK)  slot index belonging to phase_out.

## Operation
- Storage: NUM_BANKS*OPS_PER_BANK accumulators (acc[s]) and key-on history bits (kon_prev[s]), all in flops.
- Slot-index rules:
  - An index ≥ NUM_BANKS*OPS_PER_BANK (op_num ≥ OPS_PER_BANK) is ignored: no state change and no phase_valid.
  - The sequencer presents each slot at most once per sample period. The block does not need to enforce this.
- Stage 1, on the cycle slot_en=1:
  - Register slot index, phase_inc, key_on and modulation.
  - Read acc[s] and kon_prev[s].
- Stage 2, computed from the stage-1 registers:
  - If key_on=1 and kon_prev[s]=0 (rising edge): acc_next = 0.
  - Otherwise: acc_next = (acc[s] + phase_inc) mod 2^PHASE_ACC_WIDTH. There is no saturation.
  - Write acc[s] <= acc_next and kon_prev[s] <= key_on.
  - phase_out <= acc_next[PHASE_ACC_WIDTH-1 -: PHASE_OUT_WIDTH] + modulation, modulo 2^PHASE_OUT_WIDTH.
  - phase_slot <= s; phase_valid <= 1.
- Hazard: if stage 1 reads slot s while stage 2 writes s in the same cycle, stage 1 must use the forwarded acc_next/key_on, not the stale stored value.
- Key-off (key_on falling) does not touch acc. The phase keeps running during release.

## Timing
- Latency: inputs sampled at edge N (slot_en=1) produce phase_out/phase_valid/phase_slot after edge N+2, i.e. valid in the cycle following edge N+2.
- Throughput: one slot per clock. Back-to-back slot_en is supported with no bubbles.
- phase_valid is a one-cycle pulse per accepted slot. When phase_valid=0, phase_out and phase_slot hold their last values.
- Reset values (reset_n=0, asynchronous):
  - All acc = 0 and all kon_prev = 0.
  - phase_valid = 0, phase_out = 0, phase_slot = 0.
  - Pipeline registers are cleared, so in-flight slots are dropped.
- After reset_n deasserts, the first slot_en is accepted at the next edge. The first key_on=1 seen for any slot counts as a rising edge.
- slot_en=0 cycles: no accumulator or history changes.

## Test plan
- Basic accumulation:
  - Stimulus: after reset, present slot 0 (bank 0, op 0) with phase_inc=0x00400, key_on=0, modulation=0, once per "period", 4 times.
  - Required: phase_out = 1, 2, 3, 4, each 2 cycles after its slot_en, with phase_slot=0.
- Wrap-around:
  - Stimulus: drive slot 35 (bank 1, op 17) with phase_inc=0xFFC00, three times.
  - Required: acc = 0xFFC00, 0xFF800, 0xFF400; phase_out = 0x3FF, 0x3FE, 0x3FD.
- Key-on reset:
  - Stimulus: accumulate slot 5 to 0x12345, then present it with key_on=1 and phase_inc=0x400, then again with key_on=1.
  - Required: first phase_out=0 (acc=0); second phase_out=1 (no second reset). Dropping key_on to 0 and presenting again gives phase_out=2.
- Modulation:
  - Stimulus: slot 2 with acc reaching 0x3FC00 (phase 0x0FF) and modulation=0x3F0.
  - Required: phase_out=0x0EF (wraps mod 1024); stored acc is unaffected by modulation.
- Back-to-back and hazard:
  - Stimulus: slot_en on 36 consecutive cycles covering slots 0..35 with distinct increments, then slot 7 twice on consecutive cycles.
  - Required: 36 consecutive phase_valid pulses in order; the second slot-7 result includes both increments.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 one cycle after slot_en for slot 3.
  - Required: no phase_valid for that slot; all outputs 0 immediately; a later key_on=1 on slot 3 yields phase_out=0.
